// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
// Tag fields are sized for the widest supported configuration; users narrow them.
package fwd_pkg;

  localparam int SEL_REGFILE = 0;
  localparam int TAG_RD_W    = 8;
  localparam int TAG_RDY_W   = 4;

  typedef struct packed {
    logic                 vld;
    logic [TAG_RD_W-1:0]  rd;
    logic [TAG_RDY_W-1:0] rdy;
  } tag_entry_t;

  localparam tag_entry_t TAG_EMPTY = '{vld: 1'b0, rd: '0, rdy: '0};

  // A producer can never be ready before the first pipe reg, nor after the last forwarding stage.
  function automatic logic [TAG_RDY_W-1:0] clampRdy(input logic [TAG_RDY_W-1:0] rdy,
                                                    input logic [TAG_RDY_W-1:0] maxStg);
    logic [TAG_RDY_W-1:0] result;
    result = rdy;
    if (rdy == '0) begin
      result = TAG_RDY_W'(1);
    end else if (rdy > maxStg) begin
      result = maxStg;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Single-source lookup: youngest in-flight write to the same register wins,
// and a hazard is flagged when that producer is not ready by the time we reach EX.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NUM_STG = 2,
  parameter int REG_AW  = 5,
  parameter int SEL_W   = 2
) (
  input  logic                      i_used,
  input  logic [REG_AW-1:0]         i_rs,
  input  logic [NUM_STG-1:0]        i_tagVld,
  input  logic [NUM_STG*REG_AW-1:0] i_tagRd,
  input  logic [NUM_STG*SEL_W-1:0]  i_tagRdy,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_hazard
);

  logic w_found;

  // Entry s moves one stage further while we sit in EX, hence select s+1.
  always_comb begin
    o_sel    = SEL_W'(SEL_REGFILE);
    o_hazard = 1'b0;
    w_found  = 1'b0;
    if (i_used && (i_rs != '0)) begin
      for (int s = 0; s < NUM_STG; s++) begin
        if (!w_found && i_tagVld[s] && (i_tagRd[s*REG_AW +: REG_AW] == i_rs)) begin
          w_found  = 1'b1;
          o_sel    = SEL_W'(s + 1);
          o_hazard = (i_tagRdy[s*SEL_W +: SEL_W] > SEL_W'(s + 1));
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding and hazard unit: tracks in-flight register writes from EX to the last
// forwarding stage, stalls ID on late producers and registers per-source EX selects.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int FWD_STG = 2,
  parameter int SEL_W   = $clog2(FWD_STG + 1),
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic                      id_regwrite_i,
  input  logic [REG_AW-1:0]         id_rd_i,
  input  logic [SEL_W-1:0]          id_ready_stg_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      ex_valid_o,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  tag_entry_t                r_tag [FWD_STG+1];
  logic                      r_exValid;
  logic [NUM_SRC*SEL_W-1:0]  r_exSel;
  logic [CNT_W-1:0]          r_stallCnt;

  logic [FWD_STG-1:0]        w_tagVld;
  logic [FWD_STG*REG_AW-1:0] w_tagRd;
  logic [FWD_STG*SEL_W-1:0]  w_tagRdy;
  logic [NUM_SRC-1:0]        w_hazard;
  logic [NUM_SRC*SEL_W-1:0]  w_srcSel;
  logic                      w_stall;
  logic                      w_accept;
  tag_entry_t                w_newTag;

  // The oldest entry is write-before-read in the regfile, so it is never a forwarding source.
  generate
    for (genvar s = 0; s < FWD_STG; s++) begin : g_tagView
      assign w_tagVld[s]                  = r_tag[s].vld;
      assign w_tagRd[s*REG_AW +: REG_AW]  = r_tag[s].rd[REG_AW-1:0];
      assign w_tagRdy[s*SEL_W +: SEL_W]   = r_tag[s].rdy[SEL_W-1:0];
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_src_match #(
        .NUM_STG (FWD_STG),
        .REG_AW  (REG_AW),
        .SEL_W   (SEL_W)
      ) u_match (
        .i_used   (id_rs_used_i[k]),
        .i_rs     (id_rs_i[k*REG_AW +: REG_AW]),
        .i_tagVld (w_tagVld),
        .i_tagRd  (w_tagRd),
        .i_tagRdy (w_tagRdy),
        .o_sel    (w_srcSel[k*SEL_W +: SEL_W]),
        .o_hazard (w_hazard[k])
      );
    end
  endgenerate

  assign w_stall  = id_valid_i && !flush_i && (|w_hazard);
  assign w_accept = id_valid_i && !w_stall && !flush_i;

  // Writes to x0 are never tracked so that nothing ever forwards a fake x0 value.
  always_comb begin
    w_newTag = TAG_EMPTY;
    if (w_accept) begin
      w_newTag.vld = id_regwrite_i && (id_rd_i != '0);
      w_newTag.rd  = TAG_RD_W'(id_rd_i);
      w_newTag.rdy = clampRdy(TAG_RDY_W'(id_ready_stg_i), TAG_RDY_W'(FWD_STG));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s <= FWD_STG; s++) begin
        r_tag[s] <= TAG_EMPTY;
      end
      r_exValid  <= 1'b0;
      r_exSel    <= '0;
      r_stallCnt <= '0;
    end else if (!hold_i) begin
      r_tag[0] <= w_newTag;
      for (int s = 1; s <= FWD_STG; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      r_exValid <= w_accept;
      r_exSel   <= w_accept ? w_srcSel : '0;
      if (w_stall && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

  assign stall_o      = w_stall;
  assign ex_valid_o   = r_exValid;
  assign ex_fwd_sel_o = r_exSel;
  assign stall_cnt_o  = r_stallCnt;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed vector table for the hazard scenarios,
// then randomized traffic checked against a queue-based pipeline model.
module tb_fwd_scoreboard_unit;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int FWD_STG = 2;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst, valid, hold, flush, regwrite;
    logic [1:0] used;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] rdy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       expStall, expExValid;
    logic [1:0] expSel0, expSel1;
    logic [3:0] expCnt;
  } vec_t;

  typedef struct {
    bit vld;
    int rd;
    int rdy;
  } tagM_t;

  logic                      clk_i = 1'b0;
  logic                      rst_i, id_valid_i, id_regwrite_i, hold_i, flush_i;
  logic [NUM_SRC*REG_AW-1:0] id_rs_i;
  logic [NUM_SRC-1:0]        id_rs_used_i;
  logic [REG_AW-1:0]         id_rd_i;
  logic [SEL_W-1:0]          id_ready_stg_i;
  logic                      stall_o, ex_valid_o;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  int compareCount  = 0;
  int mismatchCount = 0;

  vec_t  vecs[$];
  tagM_t pipeQ[$];
  bit    mExValid;
  int    mSel[NUM_SRC];
  int    mNextSel[NUM_SRC];
  bit    mStall;
  int    mCnt;

  fwd_scoreboard_unit #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW),
    .FWD_STG (FWD_STG),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs_i        (id_rs_i),
    .id_rs_used_i   (id_rs_used_i),
    .id_regwrite_i  (id_regwrite_i),
    .id_rd_i        (id_rd_i),
    .id_ready_stg_i (id_ready_stg_i),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .ex_valid_o     (ex_valid_o),
    .ex_fwd_sel_o   (ex_fwd_sel_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic stim_t mkStim(input int rst, input int valid, input int hold, input int flush,
                                   input int rs1, input int rs2, input int used, input int regwrite,
                                   input int rd, input int rdy);
    stim_t s;
    s.rst = 1'(rst);   s.valid = 1'(valid); s.hold = 1'(hold); s.flush = 1'(flush);
    s.rs1 = 5'(rs1);   s.rs2 = 5'(rs2);     s.used = 2'(used); s.regwrite = 1'(regwrite);
    s.rd  = 5'(rd);    s.rdy = 2'(rdy);
    return s;
  endfunction

  task automatic addVec(input stim_t s, input int st, input int exv, input int sel0, input int sel1,
                        input int cnt);
    vec_t v;
    v.s = s; v.expStall = 1'(st); v.expExValid = 1'(exv);
    v.expSel0 = 2'(sel0); v.expSel1 = 2'(sel1); v.expCnt = 4'(cnt);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    rst_i          = s.rst;
    id_valid_i     = s.valid;
    hold_i         = s.hold;
    flush_i        = s.flush;
    id_rs_i        = {s.rs2, s.rs1};
    id_rs_used_i   = s.used;
    id_regwrite_i  = s.regwrite;
    id_rd_i        = s.rd;
    id_ready_stg_i = s.rdy;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compareCount++;
    if (actual != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: a queue of in-flight writes, front = instruction now in EX.
  task automatic modelReset();
    tagM_t empty;
    empty.vld = 0; empty.rd = 0; empty.rdy = 0;
    pipeQ.delete();
    for (int i = 0; i <= FWD_STG; i++) pipeQ.push_back(empty);
    mExValid = 0;
    mCnt     = 0;
    for (int k = 0; k < NUM_SRC; k++) mSel[k] = 0;
  endtask

  task automatic modelEval(input stim_t s);
    int rs[NUM_SRC];
    bit anyHaz;
    rs[0]  = s.rs1;
    rs[1]  = s.rs2;
    anyHaz = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      mNextSel[k] = 0;
      if (s.used[k] && rs[k] != 0) begin
        for (int i = 0; i < FWD_STG; i++) begin
          if (pipeQ[i].vld && pipeQ[i].rd == rs[k]) begin
            mNextSel[k] = i + 1;
            if (pipeQ[i].rdy > i + 1) anyHaz = 1;
            break;
          end
        end
      end
    end
    mStall = s.valid && !s.flush && anyHaz;
  endtask

  task automatic modelAdvance(input stim_t s);
    tagM_t e;
    bit accept;
    if (s.rst) begin
      modelReset();
    end else if (!s.hold) begin
      accept = s.valid && !mStall && !s.flush;
      e.vld  = accept && s.regwrite && (s.rd != 0);
      e.rd   = s.rd;
      e.rdy  = (s.rdy == 0) ? 1 : ((s.rdy > FWD_STG) ? FWD_STG : int'(s.rdy));
      pipeQ.push_front(e);
      void'(pipeQ.pop_back());
      mExValid = accept;
      for (int k = 0; k < NUM_SRC; k++) mSel[k] = accept ? mNextSel[k] : 0;
      if (mStall && mCnt < CNT_MAX) mCnt++;
    end
  endtask

  task automatic modelCycle(input stim_t s, input string tag);
    @(negedge clk_i);
    applyStimulus(s);
    modelEval(s);
    #1;
    checkOutput({tag, ".stall"}, stall_o, mStall);
    checkOutput({tag, ".exValid"}, ex_valid_o, mExValid);
    for (int k = 0; k < NUM_SRC; k++)
      checkOutput($sformatf("%s.sel%0d", tag, k), ex_fwd_sel_o[k*SEL_W +: SEL_W], mSel[k]);
    checkOutput({tag, ".cnt"}, stall_cnt_o, mCnt);
    @(posedge clk_i);
    modelAdvance(s);
  endtask

  task automatic rawReset();
    @(negedge clk_i);
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_i);
    modelReset();
  endtask

  initial begin
    stim_t nop, s;
    nop = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU chain
    addVec(mkStim(0,1,0,0, 1, 2,0,1, 5,1), 0,0,0,0,0);
    addVec(mkStim(0,1,0,0, 5, 0,1,1,10,1), 0,1,0,0,0);
    addVec(nop,                           0,1,1,0,0);
    // Load-use: one stall, one bubble, then WB forward
    addVec(mkStim(0,1,0,0, 0, 0,0,1, 6,2), 0,0,0,0,0);
    addVec(mkStim(0,1,0,0, 1, 6,2,1,11,1), 1,1,0,0,0);
    addVec(mkStim(0,1,0,0, 1, 6,2,1,11,1), 0,0,0,0,1);
    addVec(nop,                           0,1,0,2,1);
    // Youngest producer wins
    addVec(mkStim(0,1,0,0, 0, 0,0,1, 7,1), 0,0,0,0,1);
    addVec(mkStim(0,1,0,0, 0, 0,0,1, 7,1), 0,1,0,0,1);
    addVec(mkStim(0,1,0,0, 7, 3,1,1,12,1), 0,1,0,0,1);
    addVec(nop,                           0,1,1,0,1);
    // Per-source independence, x0 and unused sources
    addVec(mkStim(0,1,0,0, 0, 0,0,1, 9,1), 0,0,0,0,1);
    addVec(mkStim(0,1,0,0, 0, 0,0,1, 8,1), 0,1,0,0,1);
    addVec(mkStim(0,1,0,0, 8, 9,3,1, 0,1), 0,1,0,0,1);
    addVec(mkStim(0,1,0,0, 0, 8,1,0, 0,0), 0,1,1,2,1);
    addVec(mkStim(0,1,0,0, 0, 0,0,1,13,2), 0,1,0,0,1);
    addVec(mkStim(0,1,0,0,13,13,0,0, 0,0), 0,1,0,0,1);
    addVec(nop,                           0,1,0,0,1);
    // Hold during a load-use stall, then flush during a stall
    addVec(mkStim(0,1,0,0, 0, 0,0,1,14,2), 0,0,0,0,1);
    addVec(mkStim(0,1,1,0,14, 0,1,1,15,1), 1,1,0,0,1);
    addVec(mkStim(0,1,1,0,14, 0,1,1,15,1), 1,1,0,0,1);
    addVec(mkStim(0,1,1,0,14, 0,1,1,15,1), 1,1,0,0,1);
    addVec(mkStim(0,1,0,0,14, 0,1,1,15,1), 1,1,0,0,1);
    addVec(mkStim(0,1,0,0,14, 0,1,1,15,1), 0,0,0,0,2);
    addVec(nop,                           0,1,2,0,2);
    addVec(mkStim(0,1,0,0, 0, 0,0,1,16,2), 0,0,0,0,2);
    addVec(mkStim(0,1,0,1,16, 0,1,1,19,1), 0,1,0,0,2);
    addVec(nop,                           0,0,0,0,2);
    // Reset with two live entries
    addVec(mkStim(0,1,0,0, 0, 0,0,1,17,1), 0,0,0,0,2);
    addVec(mkStim(0,1,0,0, 0, 0,0,1,18,2), 0,1,0,0,2);
    addVec(mkStim(1,1,0,0,18, 0,1,1,20,1), 1,1,0,0,2);
    addVec(mkStim(0,1,0,0,18,17,3,1,21,1), 0,0,0,0,0);
    addVec(nop,                           0,1,0,0,0);

    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk_i);

    foreach (vecs[i]) begin
      @(negedge clk_i);
      applyStimulus(vecs[i].s);
      #1;
      checkOutput($sformatf("vec%0d.stall", i), stall_o, vecs[i].expStall);
      checkOutput($sformatf("vec%0d.exValid", i), ex_valid_o, vecs[i].expExValid);
      checkOutput($sformatf("vec%0d.sel0", i), ex_fwd_sel_o[SEL_W-1:0], vecs[i].expSel0);
      checkOutput($sformatf("vec%0d.sel1", i), ex_fwd_sel_o[2*SEL_W-1:SEL_W], vecs[i].expSel1);
      checkOutput($sformatf("vec%0d.cnt", i), stall_cnt_o, vecs[i].expCnt);
      @(posedge clk_i);
    end

    // Counter saturation: repeated load-use pairs exceed the counter range
    rawReset();
    for (int n = 0; n < CNT_MAX + 3; n++) begin
      modelCycle(mkStim(0,1,0,0, 0,0,0,1,20,2), $sformatf("sat%0d.ld", n));
      modelCycle(mkStim(0,1,0,0,20,0,1,0, 0,1), $sformatf("sat%0d.use", n));
      modelCycle(mkStim(0,1,0,0,20,0,1,0, 0,1), $sformatf("sat%0d.go", n));
    end
    @(negedge clk_i);
    applyStimulus(nop);
    #1;
    checkOutput("satCount", stall_cnt_o, CNT_MAX);

    // Randomized traffic against the model
    rawReset();
    for (int n = 0; n < 800; n++) begin
      s.rst      = ($urandom_range(0, 99) < 3);
      s.valid    = ($urandom_range(0, 99) < 75);
      s.hold     = ($urandom_range(0, 99) < 10);
      s.flush    = ($urandom_range(0, 99) < 8);
      s.regwrite = ($urandom_range(0, 99) < 70);
      s.used     = 2'($urandom_range(0, 3));
      s.rs1      = 5'($urandom_range(0, 7));
      s.rs2      = 5'($urandom_range(0, 7));
      s.rd       = 5'($urandom_range(0, 7));
      s.rdy      = 2'($urandom_range(0, 3));
      modelCycle(s, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
